// File: rtl/tick_gen_pkg.sv
// Shared types and defaults for the multi-channel programmable tick divider.
package tick_gen_pkg;

    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned DEF_NUM_CH = 4;

    // Config fields use a fixed container width; channels zero-extend CNT_W values into it.
    localparam int unsigned CFG_W = 32;

    typedef enum logic {STOP, RUN} ch_state_e;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
    } ch_cfg_t;

    function automatic ch_cfg_t make_cfg(input logic [CFG_W-1:0] div,
                                         input logic [CFG_W-1:0] high);
        ch_cfg_t c;
        c.div  = div;
        c.high = high;
        return c;
    endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Configuration handshake bundle for tick_gen: master drives requests, slave returns ready.
interface tick_gen_if #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, output cfg_high,
                    input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, input cfg_high,
                    output cfg_ready);

endinterface

// File: rtl/tick_gen_ch.sv
// One divider channel: counter, active/shadow config, pending flag and registered outputs.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int unsigned       CNT_W        = DEF_CNT_W,
    parameter logic [CNT_W-1:0]  DEFAULT_DIV  = '0,
    parameter logic [CNT_W-1:0]  DEFAULT_HIGH = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             ch_en,
    input  logic             restart,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam ch_cfg_t RESET_CFG = '{div: CFG_W'(DEFAULT_DIV), high: CFG_W'(DEFAULT_HIGH)};

    ch_state_e        state_q, state_d;
    ch_cfg_t          act_q, act_d, shd_q, shd_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d, tick_q, tick_d;
    logic             wrap, apply;

    always_comb begin
        wrap  = (state_q == RUN) && (CFG_W'(cnt_q) == act_q.div - CFG_W'(1));
        apply = pend_q && (restart || (state_q == STOP) || wrap);

        act_d  = apply ? shd_q : act_q;
        shd_d  = cfg_we ? make_cfg(CFG_W'(cfg_div), CFG_W'(cfg_high)) : shd_q;
        // A write can only land while pending is clear, so set and clear never collide.
        pend_d = cfg_we || (pend_q && !apply);

        state_d = (ch_en && (act_d.div != '0)) ? RUN : STOP;

        if ((state_d == STOP) || (state_q == STOP) || restart || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        clk_out_d = (state_d == RUN) && (CFG_W'(cnt_d) < act_d.high);
        tick_d    = (state_d == RUN) && (CFG_W'(cnt_d) == act_d.div - CFG_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= STOP;
            act_q     <= RESET_CFG;
            shd_q     <= RESET_CFG;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            shd_q     <= shd_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable clock/tick divider: cfg_ch decode, ready mux and channel array.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned      CNT_W        = DEF_CNT_W,
    parameter int unsigned      NUM_CH       = DEF_NUM_CH,
    parameter logic [CNT_W-1:0] DEFAULT_DIV  = CNT_W'(64'd1 << 16),
    parameter logic [CNT_W-1:0] DEFAULT_HIGH = DEFAULT_DIV >> 1
) (
    input  logic              clk,
    input  logic              reset,
    tick_gen_if.slave         cfg,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              restart,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SEL_N = 1 << CH_W;

    // Out-of-range channel indices see a zero pending bit, so they are accepted and dropped.
    logic [SEL_N-1:0]  pending_ext;
    logic              ready;
    logic [NUM_CH-1:0] cfg_we;

    assign pending_ext   = SEL_N'(pending);
    assign ready         = !pending_ext[cfg.cfg_ch];
    assign cfg.cfg_ready = ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign cfg_we[i] = cfg.cfg_valid && ready && (cfg.cfg_ch == CH_W'(i));

        tick_gen_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_HIGH (DEFAULT_HIGH)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .cfg_we   (cfg_we[i]),
            .cfg_div  (cfg.cfg_div),
            .cfg_high (cfg.cfg_high),
            .ch_en    (ch_en[i]),
            .restart  (restart),
            .clk_out  (clk_out[i]),
            .tick     (tick[i]),
            .pending  (pending[i])
        );
    end

endmodule
